// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if: codec serial pins plus parallel sample outputs of i2s_receiver.
// The peak meter signal exists only when I2S_RX_PEAK_EN is defined.
interface i2s_receiver_if #(parameter int DATA_W = 16);
  logic audio_sck, audio_lrck, audio_sdout;
  logic [DATA_W-1:0] lChannel, rChannel;
  logic sample_valid, frame_err;
`ifdef I2S_RX_PEAK_EN
  logic [DATA_W-1:0] peak;
`endif
  modport master (
    output audio_sck, audio_lrck, audio_sdout,
    input lChannel, rChannel, sample_valid, frame_err
`ifdef I2S_RX_PEAK_EN
    , input peak
`endif
  );
  modport slave (
    input audio_sck, audio_lrck, audio_sdout,
    output lChannel, rChannel, sample_valid, frame_err
`ifdef I2S_RX_PEAK_EN
    , output peak
`endif
  );
endinterface

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling Philips I2S deserializer delivering 16-bit L/R pairs with a valid pulse.
// Define I2S_RX_PEAK_EN to add the decaying peak level meter.
module i2s_receiver #(parameter int DATA_W = 16) (
  input logic clk,
  input logic rst,
  i2s_receiver_if.slave bus
);
  localparam logic [1:0] SYNC = 2'd0, LEFT = 2'd1, RIGHT = 2'd2;
  logic [1:0] sckSync, lrSync, sdSync, state;
  logic sckPrev, lrQ, sckRise, boundary, deliver, sampleValid, frameErr;
  logic [DATA_W-1:0] shreg, bitMask, lHold, lChannel, rChannel;
  assign sckRise = sckSync[1] & ~sckPrev;
  assign boundary = sckRise & (lrSync[1] != lrQ);
  assign deliver = boundary & (state == RIGHT);
  // bitMask walks a single one from MSB down; once empty, further bits in the word are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      sckSync <= '0;
      lrSync <= '0;
      sdSync <= '0;
      sckPrev <= 1'b0;
      lrQ <= 1'b0;
      state <= SYNC;
      shreg <= '0;
      bitMask <= '0;
      lHold <= '0;
      lChannel <= '0;
      rChannel <= '0;
      sampleValid <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      sckSync <= {sckSync[0], bus.audio_sck};
      lrSync <= {lrSync[0], bus.audio_lrck};
      sdSync <= {sdSync[0], bus.audio_sdout};
      sckPrev <= sckSync[1];
      sampleValid <= deliver;
      if (sckRise) begin
        lrQ <= lrSync[1];
        if (boundary) begin
          shreg <= '0;
          bitMask <= {1'b1, {(DATA_W-1){1'b0}}};
          state <= state == SYNC ? (lrSync[1] ? SYNC : LEFT) : state == LEFT ? RIGHT : LEFT;
          if (state == LEFT) lHold <= shreg;
          if (deliver) begin
            lChannel <= lHold;
            rChannel <= shreg;
          end
          if (state != SYNC && bitMask != '0) frameErr <= 1'b1;
        end else begin
          shreg <= shreg | (bitMask & {DATA_W{sdSync[1]}});
          bitMask <= bitMask >> 1;
        end
      end
    end
  end
  assign bus.lChannel = lChannel;
  assign bus.rChannel = rChannel;
  assign bus.sample_valid = sampleValid;
  assign bus.frame_err = frameErr;
`ifdef I2S_RX_PEAK_EN
  localparam logic [DATA_W-1:0] MAG_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    return x == MAG_MIN ? MAG_MAX : x[DATA_W-1] ? -x : x;
  endfunction
  logic [DATA_W-1:0] peakReg, lMag, rMag, frameMag;
  assign lMag = magnitude(lHold);
  assign rMag = magnitude(shreg);
  assign frameMag = lMag > rMag ? lMag : rMag;
  // updates alongside the delivered pair, so peak reflects exactly the samples on lChannel/rChannel
  always_ff @(posedge clk) begin
    if (rst) peakReg <= '0;
    else if (deliver) peakReg <= frameMag > peakReg ? frameMag : peakReg - (peakReg >> 6);
  end
  assign bus.peak = peakReg;
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: drives randomized I2S frames and checks decoded pairs against a word-level model.
module tb_i2s_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  i2s_receiver_if #(.DATA_W(16)) bus();
  i2s_receiver #(.DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0, bad = 0, halfP = 16, wide = 0;
  logic prevV = 1'b0;
  logic expErr = 1'b0;
  logic [31:0] gotQ[$], expQ[$];
`ifdef I2S_RX_PEAK_EN
  logic [15:0] expPeak = '0;
`endif
  always @(negedge clk) begin
    if (bus.sample_valid) gotQ.push_back({bus.lChannel, bus.rChannel});
    if (bus.sample_valid && prevV) wide++;
    prevV = bus.sample_valid;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic modelReset();
    expErr = 1'b0;
`ifdef I2S_RX_PEAK_EN
    expPeak = '0;
`endif
  endtask
  task automatic clockBit(input logic lr, input logic sd, input bit pulseRst);
    bus.audio_sck = 1'b0;
    bus.audio_lrck = lr;
    bus.audio_sdout = sd;
    if (pulseRst) begin
      rst = 1'b1;
      waitClk(1);
      rst = 1'b0;
      modelReset();
      check("rst_mid_l", bus.lChannel, 0);
      check("rst_mid_r", bus.rChannel, 0);
      check("rst_mid_valid", bus.sample_valid, 0);
      check("rst_mid_err", bus.frame_err, 0);
      waitClk(halfP - 1);
    end else waitClk(halfP);
    bus.audio_sck = 1'b1;
    waitClk(halfP);
  endtask
  // slot 0 carries the previous word's LSB; slots past nbits are random padding
  task automatic sendWord(input logic lr, input logic [31:0] data, input int nbits, input int wordLen, input int rstSlot);
    for (int i = 0; i < wordLen; i++)
      clockBit(lr, (i >= 1 && i <= nbits) ? data[nbits-i] : 1'($urandom), i == rstSlot);
  endtask
  function automatic logic [15:0] expWord(input logic [31:0] data, input int nbits);
    return nbits >= 16 ? 16'(data >> (nbits - 16)) : 16'(data << (16 - nbits));
  endfunction
`ifdef I2S_RX_PEAK_EN
  function automatic logic [15:0] mag(input logic [15:0] x);
    int v;
    v = $signed(x);
    v = v < 0 ? -v : v;
    return v > 32767 ? 16'h7FFF : 16'(v);
  endfunction
`endif
  task automatic sendFrame(input logic [31:0] l, input logic [31:0] r, input int nb, input int wl);
    logic [15:0] el, er;
    sendWord(1'b0, l, nb, wl, -1);
    sendWord(1'b1, r, nb, wl, -1);
    el = expWord(l, nb);
    er = expWord(r, nb);
    expQ.push_back({el, er});
    if (nb < 16) expErr = 1'b1;
`ifdef I2S_RX_PEAK_EN
    begin
      logic [15:0] m;
      m = mag(el) > mag(er) ? mag(el) : mag(er);
      expPeak = m > expPeak ? m : expPeak - expPeak / 64;
    end
`endif
  endtask
  task automatic endSeg(input string tag);
    sendWord(1'b0, 0, 0, 2, -1);
    waitClk(6);
    check({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) check({tag, "_pair"}, gotQ[i], expQ[i]);
    check({tag, "_err"}, bus.frame_err, expErr);
    check({tag, "_wide"}, wide, 0);
`ifdef I2S_RX_PEAK_EN
    check({tag, "_peak"}, bus.peak, expPeak);
`endif
    gotQ.delete();
    expQ.delete();
  endtask
  task automatic doReset();
    rst = 1'b1;
    waitClk(2);
    rst = 1'b0;
    modelReset();
    gotQ.delete();
    expQ.delete();
    wide = 0;
  endtask
  initial begin
    bus.audio_sck = 1'b0;
    bus.audio_lrck = 1'b0;
    bus.audio_sdout = 1'b0;
    waitClk(3);
    check("reset_l", bus.lChannel, 0);
    check("reset_r", bus.rChannel, 0);
    check("reset_valid", bus.sample_valid, 0);
    check("reset_err", bus.frame_err, 0);
`ifdef I2S_RX_PEAK_EN
    check("reset_peak", bus.peak, 0);
`endif
    rst = 1'b0;
    sendWord(1'b1, $urandom, 16, 32, -1);
    sendFrame(32'h8001, 32'h7FFE, 16, 32);
    endSeg("basic");
    check("basic_l", bus.lChannel, 16'h8001);
    check("basic_r", bus.rChannel, 16'h7FFE);
    halfP = 4;
    doReset();
    sendWord(1'b1, $urandom, 16, 32, -1);
    repeat (6) sendFrame($urandom, $urandom, $urandom_range(16, 24), 32);
    endSeg("random");
    repeat (5) clockBit(1'b1, 1'($urandom), 1'b0);
    doReset();
    repeat (10) clockBit(1'b1, 1'($urandom), 1'b0);
    sendFrame($urandom, $urandom, 16, 32);
    check("align_early", gotQ.size(), 0);
    sendFrame($urandom, $urandom, 16, 32);
    endSeg("align");
    doReset();
    sendWord(1'b1, $urandom, 16, 32, -1);
    sendFrame(32'hABC, 32'h123, 12, 13);
    sendFrame($urandom, $urandom, 16, 32);
    endSeg("short");
    check("short_sticky", bus.frame_err, 1);
    doReset();
    check("short_cleared", bus.frame_err, expErr);
    sendWord(1'b1, $urandom, 16, 32, -1);
    sendFrame($urandom | 32'h1, $urandom | 32'h1, 16, 32);
    sendWord(1'b0, $urandom, 16, 32, -1);
    sendWord(1'b1, $urandom, 16, 32, 8);
    sendFrame($urandom, $urandom, 16, 32);
    sendFrame($urandom, $urandom, 16, 32);
    endSeg("midrst");
    doReset();
    sendWord(1'b1, $urandom, 16, 20, -1);
    for (int i = 0; i < 100; i++) sendFrame(32'h1000 + i, 32'hF000 - 3 * i, 16, 20);
    endSeg("b2b");
`ifdef I2S_RX_PEAK_EN
    doReset();
    sendWord(1'b1, $urandom, 16, 32, -1);
    sendFrame(32'h8000, 32'h0, 16, 32);
    sendFrame(32'h0, 32'h0, 16, 32);
    check("peak_full", bus.peak, 16'h7FFF);
    endSeg("peak");
    check("peak_decay", bus.peak, 16'h7E00);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
